// File: rtl/ctrl_word_pipeline.sv
// Microinstruction pipeline register: STAGES-deep control-word/state pipe with
// valid/ready, stall, flush-to-NOP and a wait-state hold. Optional: CTRL_PARITY_EN.
module ctrl_word_pipeline #(
    parameter int unsigned         WORD_W   = 38,
    parameter int unsigned         STATE_W  = 10,
    parameter int unsigned         CR_W     = 10,
    parameter int unsigned         STAGES   = 1,
    parameter int unsigned         WAIT_LSB = 35,
    parameter int unsigned         WAIT_W   = 3,
    parameter logic [WORD_W-1:0]   NOP_WORD = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  data_in,
    input  logic [STATE_W-1:0] current_state,
    input  logic               stall,
    input  logic               flush,
`ifdef CTRL_PARITY_EN
    input  logic               data_par,
    output logic               par_err,
`endif
    output logic               out_valid,
    output logic [WORD_W-1:0]  ctrl_word,
    output logic [STATE_W-1:0] curr_state,
    output logic [CR_W-1:0]    cr,
    output logic               wait_busy
);

    typedef struct packed {
        logic               valid;
        logic [WORD_W-1:0]  word;
        logic [STATE_W-1:0] state;
    } stage_t;

    localparam stage_t NOP_STAGE = {1'b0, NOP_WORD, {STATE_W{1'b0}}};

    stage_t              stage_q [STAGES];
    stage_t              stage_d [STAGES];
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_d;
    logic                busy;

    assign busy     = stall | (wait_cnt_q != '0);
    assign in_ready = ~busy & ~flush;

    // Flush outranks stall and wait; the wait hold freezes every stage, not just the last.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        stage_d    = stage_q;
        wait_cnt_d = wait_cnt_q;
        if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_d[k] = NOP_STAGE;
            end
            wait_cnt_d = '0;
        end else if (!stall) begin
            if (wait_cnt_q != '0) begin
                wait_cnt_d = wait_cnt_q - WAIT_W'(1);
            end else begin
                stage_d[0] = {in_valid, data_in, current_state};
                for (int k = 1; k < STAGES; k++) begin
                    stage_d[k] = stage_q[k-1];
                end
                // Only a valid word arriving at the output may start a hold.
                if (stage_d[STAGES-1].valid) begin
                    wait_cnt_d = stage_d[STAGES-1].word[WAIT_LSB +: WAIT_W];
                end
            end
        end
    end

    // NOTE: the stage array is small and feeds control lines directly, so it is reset
    // to NOP rather than left uninitialised like a datapath memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= NOP_STAGE;
            end
            wait_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            stage_q    <= stage_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef CTRL_PARITY_EN
    logic par_err_q;
    logic par_err_d;

    always_comb begin
        par_err_d = par_err_q | (in_ready & in_valid & (^{data_in, data_par}));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

    assign out_valid  = stage_q[STAGES-1].valid;
    assign ctrl_word  = stage_q[STAGES-1].word;
    assign curr_state = stage_q[STAGES-1].state;
    assign cr         = stage_q[STAGES-1].word[CR_W-1:0];
    assign wait_busy  = (wait_cnt_q != '0);

endmodule

// File: tb/tb_ctrl_word_pipeline.sv
// Directed bench for ctrl_word_pipeline: a STAGES=1 instance (u1) and a STAGES=3 instance (u3).
module tb_ctrl_word_pipeline;

    logic        clk;
    logic        reset_n;

    logic        v1, st1, fl1, p1;
    logic [37:0] d1;
    logic [9:0]  s1;
    logic        rdy1, ov1, wb1;
    logic [37:0] cw1;
    logic [9:0]  cs1, cr1;
`ifdef CTRL_PARITY_EN
    logic        pe1, pe3;
`endif

    logic        v3, st3, fl3, p3;
    logic [37:0] d3;
    logic [9:0]  s3;
    logic        rdy3, ov3, wb3;
    logic [37:0] cw3;
    logic [9:0]  cs3, cr3;

    int n_checks;
    int n_pass;

    ctrl_word_pipeline #(.STAGES(1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(rdy1),
        .data_in(d1), .current_state(s1), .stall(st1), .flush(fl1),
`ifdef CTRL_PARITY_EN
        .data_par(p1), .par_err(pe1),
`endif
        .out_valid(ov1), .ctrl_word(cw1), .curr_state(cs1), .cr(cr1), .wait_busy(wb1)
    );

    ctrl_word_pipeline #(.STAGES(3)) u3 (
        .clk(clk), .reset_n(reset_n), .in_valid(v3), .in_ready(rdy3),
        .data_in(d3), .current_state(s3), .stall(st3), .flush(fl3),
`ifdef CTRL_PARITY_EN
        .data_par(p3), .par_err(pe3),
`endif
        .out_valid(ov3), .ctrl_word(cw3), .curr_state(cs3), .cr(cr3), .wait_busy(wb3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        n_checks++; if (ov1 !== 1'b0) $display("FAIL rst_valid: got %b want 0", ov1); else n_pass++;
        n_checks++; if (cw1 !== 38'h0) $display("FAIL rst_word: got %h want 0", cw1); else n_pass++;
        n_checks++; if (cs1 !== 10'd0) $display("FAIL rst_state: got %0d want 0", cs1); else n_pass++;
        n_checks++; if (wb1 !== 1'b0) $display("FAIL rst_wait: got %b want 0", wb1); else n_pass++;
        n_checks++; if (ov3 !== 1'b0) $display("FAIL rst_valid3: got %b want 0", ov3); else n_pass++;
        #2 reset_n = 1'b1;
        // load a valid word, then pull reset mid-cycle
        v1 = 1'b1; d1 = 38'h0_0000_0155; s1 = 10'd7;
        step();
        v1 = 1'b0;
        n_checks++; if (ov1 !== 1'b1) $display("FAIL rst_preload: got %b want 1", ov1); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (ov1 !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", ov1); else n_pass++;
        n_checks++; if (cw1 !== 38'h0) $display("FAIL rst_async_word: got %h want 0", cw1); else n_pass++;
        n_checks++; if (cs1 !== 10'd0) $display("FAIL rst_async_state: got %0d want 0", cs1); else n_pass++;
        n_checks++; if (cr1 !== 10'd0) $display("FAIL rst_async_cr: got %h want 0", cr1); else n_pass++;
        // reset during a wait hold
        reset_n = 1'b1;
        v1 = 1'b1; d1 = 38'h18_0000_002A; s1 = 10'd9;
        step();
        v1 = 1'b0;
        n_checks++; if (wb1 !== 1'b1) $display("FAIL rst_prewait: got %b want 1", wb1); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (wb1 !== 1'b0) $display("FAIL rst_midwait_busy: got %b want 0", wb1); else n_pass++;
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL rst_midwait_ready: got %b want 1", rdy1); else n_pass++;
        reset_n = 1'b1;
        d1 = 38'h0; s1 = 10'd0;
        step();
    endtask

    task automatic test_basic();
        v1 = 1'b1; d1 = 38'h0_0000_0155; s1 = 10'd7;
        #1;
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL basic_ready_pre: got %b want 1", rdy1); else n_pass++;
        step();
        v1 = 1'b0;
        n_checks++; if (ov1 !== 1'b1) $display("FAIL basic_valid: got %b want 1", ov1); else n_pass++;
        n_checks++; if (cw1 !== 38'h155) $display("FAIL basic_word: got %h want 155", cw1); else n_pass++;
        n_checks++; if (cs1 !== 10'd7) $display("FAIL basic_state: got %0d want 7", cs1); else n_pass++;
        n_checks++; if (cr1 !== 10'h155) $display("FAIL basic_cr: got %h want 155", cr1); else n_pass++;
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL basic_ready_post: got %b want 1", rdy1); else n_pass++;
        n_checks++; if (wb1 !== 1'b0) $display("FAIL basic_wait: got %b want 0", wb1); else n_pass++;
        step();
        n_checks++; if (ov1 !== 1'b0) $display("FAIL basic_bubble: got %b want 0", ov1); else n_pass++;
    endtask

    task automatic test_wait();
        v1 = 1'b1; d1 = 38'h18_0000_002A; s1 = 10'd9;
        step();
        d1 = 38'h0_0000_0033; s1 = 10'd10;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cw1 !== 38'h18_0000_002A || ov1 !== 1'b1)
                $display("FAIL wait_hold[%0d]: got %b/%h want 1/18_0000_002a", i, ov1, cw1); else n_pass++;
            n_checks++; if (wb1 !== (i < 3))
                $display("FAIL wait_busy[%0d]: got %b want %b", i, wb1, (i < 3)); else n_pass++;
            n_checks++; if (rdy1 !== (i == 3))
                $display("FAIL wait_ready[%0d]: got %b want %b", i, rdy1, (i == 3)); else n_pass++;
            step();
        end
        v1 = 1'b0;
        n_checks++; if (cw1 !== 38'h33) $display("FAIL wait_next_word: got %h want 33", cw1); else n_pass++;
        n_checks++; if (cs1 !== 10'd10) $display("FAIL wait_next_state: got %0d want 10", cs1); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        v1 = 1'b1; d1 = 38'h0AA; s1 = 10'd1;
        step();
        n_checks++; if (cw1 !== 38'h0AA || cs1 !== 10'd1)
            $display("FAIL b2b_first: got %h/%0d want 0aa/1", cw1, cs1); else n_pass++;
        d1 = 38'h0BB; s1 = 10'd2;
        step();
        n_checks++; if (cw1 !== 38'h0BB || cs1 !== 10'd2 || ov1 !== 1'b1)
            $display("FAIL b2b_second: got %h/%0d/%b want 0bb/2/1", cw1, cs1, ov1); else n_pass++;
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL b2b_ready: got %b want 1", rdy1); else n_pass++;
        // bubble carrying a nonzero wait field must not start a hold
        v1 = 1'b0; d1 = 38'h38_0000_0000; s1 = 10'd3;
        step();
        n_checks++; if (ov1 !== 1'b0) $display("FAIL b2b_bubble_valid: got %b want 0", ov1); else n_pass++;
        n_checks++; if (wb1 !== 1'b0) $display("FAIL b2b_bubble_wait: got %b want 0", wb1); else n_pass++;
        n_checks++; if (cw1 !== 38'h38_0000_0000) $display("FAIL b2b_bubble_data: got %h want 38_0000_0000", cw1); else n_pass++;
        d1 = 38'h0; s1 = 10'd0;
        step();
    endtask

    task automatic test_stall();
        v3 = 1'b1; d3 = 38'h101; s3 = 10'd1;
        step();
        n_checks++; if (ov3 !== 1'b0) $display("FAIL stall_lat1: got %b want 0", ov3); else n_pass++;
        d3 = 38'h102; s3 = 10'd2;
        step();
        n_checks++; if (ov3 !== 1'b0) $display("FAIL stall_lat2: got %b want 0", ov3); else n_pass++;
        d3 = 38'h103; s3 = 10'd3;
        step();
        n_checks++; if (ov3 !== 1'b1 || cs3 !== 10'd1)
            $display("FAIL stall_out1: got %b/%0d want 1/1", ov3, cs3); else n_pass++;
        st3 = 1'b1; d3 = 38'h163; s3 = 10'd99;
        #1;
        n_checks++; if (rdy3 !== 1'b0) $display("FAIL stall_ready: got %b want 0", rdy3); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (ov3 !== 1'b1 || cs3 !== 10'd1 || cw3 !== 38'h101)
                $display("FAIL stall_frozen[%0d]: got %b/%0d/%h want 1/1/101", i, ov3, cs3, cw3); else n_pass++;
        end
        st3 = 1'b0; v3 = 1'b0;
        step();
        n_checks++; if (ov3 !== 1'b1 || cs3 !== 10'd2 || cw3 !== 38'h102)
            $display("FAIL stall_out2: got %b/%0d/%h want 1/2/102", ov3, cs3, cw3); else n_pass++;
        step();
        n_checks++; if (ov3 !== 1'b1 || cs3 !== 10'd3)
            $display("FAIL stall_out3: got %b/%0d want 1/3", ov3, cs3); else n_pass++;
        step();
        n_checks++; if (ov3 !== 1'b0) $display("FAIL stall_drained: got %b/%0d want 0", ov3, cs3); else n_pass++;
        d3 = 38'h0; s3 = 10'd0;
        step();
    endtask

    task automatic test_flush();
        v1 = 1'b1; d1 = 38'h28_0000_0044; s1 = 10'd4;
        step();
        v1 = 1'b0;
        n_checks++; if (wb1 !== 1'b1) $display("FAIL flush_hold1: got %b want 1", wb1); else n_pass++;
        step();
        n_checks++; if (cw1 !== 38'h28_0000_0044) $display("FAIL flush_hold2: got %h want 28_0000_0044", cw1); else n_pass++;
        fl1 = 1'b1; v1 = 1'b1; d1 = 38'h77; s1 = 10'd12;
        #1;
        n_checks++; if (rdy1 !== 1'b0) $display("FAIL flush_ready_in: got %b want 0", rdy1); else n_pass++;
        step();
        fl1 = 1'b0; v1 = 1'b0; d1 = 38'h0; s1 = 10'd0;
        #1;
        n_checks++; if (ov1 !== 1'b0) $display("FAIL flush_valid: got %b want 0", ov1); else n_pass++;
        n_checks++; if (cw1 !== 38'h0) $display("FAIL flush_word: got %h want 0", cw1); else n_pass++;
        n_checks++; if (wb1 !== 1'b0) $display("FAIL flush_wait: got %b want 0", wb1); else n_pass++;
        n_checks++; if (rdy1 !== 1'b1) $display("FAIL flush_ready_out: got %b want 1", rdy1); else n_pass++;
        step();
        n_checks++; if (ov1 !== 1'b0 || cs1 !== 10'd0)
            $display("FAIL flush_dropped: got %b/%0d want 0/0", ov1, cs1); else n_pass++;
        // flush wins over a simultaneous stall
        v3 = 1'b1; d3 = 38'h105; s3 = 10'd5;
        step();
        v3 = 1'b0;
        step();
        step();
        n_checks++; if (ov3 !== 1'b1 || cs3 !== 10'd5)
            $display("FAIL flush_pre3: got %b/%0d want 1/5", ov3, cs3); else n_pass++;
        st3 = 1'b1; fl3 = 1'b1;
        step();
        st3 = 1'b0; fl3 = 1'b0;
        n_checks++; if (ov3 !== 1'b0 || cw3 !== 38'h0)
            $display("FAIL flush_over_stall: got %b/%h want 0/0", ov3, cw3); else n_pass++;
    endtask

`ifdef CTRL_PARITY_EN
    task automatic test_parity();
        v1 = 1'b1; d1 = 38'h1; p1 = 1'b0;
        step();
        n_checks++; if (pe1 !== 1'b1) $display("FAIL par_set: got %b want 1", pe1); else n_pass++;
        d1 = 38'h3; p1 = 1'b0;
        step();
        v1 = 1'b0;
        step();
        n_checks++; if (pe1 !== 1'b1) $display("FAIL par_sticky: got %b want 1", pe1); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (pe1 !== 1'b0) $display("FAIL par_reset: got %b want 0", pe1); else n_pass++;
        reset_n = 1'b1;
        d1 = 38'h0;
        step();
    endtask
`endif

    initial begin
        n_checks = 0; n_pass = 0;
        v1 = 1'b0; st1 = 1'b0; fl1 = 1'b0; p1 = 1'b0; d1 = '0; s1 = '0;
        v3 = 1'b0; st3 = 1'b0; fl3 = 1'b0; p3 = 1'b0; d3 = '0; s3 = '0;
        test_reset();
        test_basic();
        test_wait();
        test_back_to_back();
        test_stall();
        test_flush();
`ifdef CTRL_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_word_pipeline.md
Name: ctrl_word_pipeline

Overview:
Parametrised microinstruction pipeline register for the microprogrammed control unit. Sits between the microstore/next-state logic and the datapath control lines. Registers the control word and current state through STAGES stages, with valid/ready handshake, stall, flush-to-NOP and a wait-state counter driven by a field of the control word. Downstream decode slices individual control signals from ctrl_word.

Parameters:
WORD_W, 38, control word width
STATE_W, 10, current-state width
CR_W, 10, next-state (cr) field width, taken from ctrl_word[CR_W-1:0]
STAGES, 1, pipeline depth (>=1)
WAIT_LSB, 35, lsb of wait-count field in control word
WAIT_W, 3, wait-count field width (WAIT_LSB+WAIT_W <= WORD_W)
NOP_WORD, 0, word loaded on reset/flush (WORD_W bits)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  data_in/current_state valid
in_ready  out  1  block accepts input this cycle
data_in  in  WORD_W  control word from microstore
current_state  in  STATE_W  state number of data_in
stall  in  1  freeze entire pipeline
flush  in  1  synchronous clear to NOP
out_valid  out  1  last stage holds valid word
ctrl_word  out  WORD_W  last-stage control word
curr_state  out  STATE_W  last-stage state number
cr  out  CR_W  ctrl_word[CR_W-1:0]
wait_busy  out  1  wait counter nonzero

Behaviour:
- Reset (async, reset_n=0): all stage valids 0, all words = NOP_WORD, all states 0, wait_cnt 0; hence out_valid=0, ctrl_word=NOP_WORD, curr_state=0, cr=NOP_WORD[CR_W-1:0], wait_busy=0. Reset mid-wait or mid-stall aborts immediately.
- busy = stall | (wait_cnt != 0); in_ready = !busy & !flush (combinational).
- Advance (busy=0, flush=0) on clk: stage0 <= {in_valid, data_in, current_state}; stage k <= stage k-1. A bubble (in_valid=0) still advances; bubble words keep their data but valid=0.
- Latency: word accepted at edge E appears at output after edge E+STAGES-1 (STAGES=1: visible the cycle after acceptance).
- Wait states: when a valid word enters the last stage with field W = word[WAIT_LSB+:WAIT_W], wait_cnt <= W on that same edge. While wait_cnt != 0 and stall=0, wait_cnt decrements by 1 per cycle and the whole pipeline holds. Word therefore stays on the output W+1 cycles. W=0 -> no hold. Bubbles never load wait_cnt.
- stall=1: all stages and wait_cnt frozen; inputs ignored; outputs constant.
- flush=1 (priority over stall and wait): on edge, all valids 0, words NOP_WORD, states 0, wait_cnt 0. Input in that cycle is dropped (in_ready=0).
- Simultaneous stall and flush: flush wins. Flush during reset: reset wins.
- wait_cnt is WAIT_W bits; never wraps (decrement stops at 0).
- out_valid, ctrl_word, curr_state, cr, wait_busy driven directly from registers (no combinational path from inputs).

Optional Feature:
CTRL_PARITY_EN: when defined, adds input data_par (1 bit, even parity over data_in) and output par_err (1 bit). On each accepted valid word, if ^{data_in,data_par} = 1, par_err sets and stays set (sticky) until reset_n. Bubbles and flushed cycles are not checked. When not defined, neither port exists and no parity logic is built.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle with a valid word loaded -> out_valid=0, ctrl_word=0, curr_state=0, wait_busy=0 immediately, without a clock edge.
- Basic pass, STAGES=1: data_in=38'h0_0000_0155 (W=0), current_state=10'd7, in_valid=1 -> next cycle out_valid=1, ctrl_word=38'h155, curr_state=7, cr=10'h155; in_ready stays 1.
- Wait: word with bits[37:35]=3'd3 -> held on output 4 cycles; wait_busy=1 and in_ready=0 for 3 cycles; next word appears on the 5th cycle.
- Stall: STAGES=3, stream states 1,2,3 and assert stall 2 cycles mid-stream -> outputs frozen 2 cycles, order 1,2,3 preserved, no loss or duplication.
- Flush during wait (W=5, flush on 2nd held cycle) -> next cycle out_valid=0, ctrl_word=NOP_WORD, wait_busy=0, in_ready=1; input offered in the flush cycle never appears.
- With CTRL_PARITY_EN: accept word 38'h1 with data_par=0 -> par_err=1 next cycle and remains 1 through further good words until reset_n=0.
